// File: rtl/serializador_pkg.sv
// Types and defaults shared by the serializer and the downstream registrador.
package serializador_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
  localparam int DEF_WIDTH = 4;
  localparam int REG_WIDTH = 4;
endpackage

// File: rtl/serializador_registrador.sv
// Downstream serial-in shift register: newest bit enters at q[W-1], oldest drains toward q[0].
module serializador_registrador
  import serializador_pkg::*;
#(
  parameter int W = REG_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         serial_in,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q <= '0;
    else        q <= {serial_in, q[W-1:1]};
  end

endmodule

// File: rtl/serializador.sv
// Parallel-to-serial converter with a one-word holding buffer so words stream gap-free.
module serializador
  import serializador_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             frame_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] buf_q;
  logic             buf_full;
  logic             accept;

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shifted(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign load_ready = ~buf_full;
  assign accept     = load_valid & load_ready;
  assign busy       = (state == SHIFT);

  // The first bit is driven straight into serial_out on load, so sr only
  // holds the bits still to come; that keeps serial_out registered with no bubble.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sr         <= '0;
      buf_q      <= '0;
      buf_full   <= 1'b0;
      serial_out <= 1'b0;
      frame_out  <= 1'b0;
    end else begin
      frame_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            sr         <= shifted(data_in);
            serial_out <= first_bit(data_in);
            cnt        <= '0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != LAST) begin
            serial_out <= first_bit(sr);
            sr         <= shifted(sr);
            cnt        <= cnt + CW'(1);
            if (accept) begin
              buf_q    <= data_in;
              buf_full <= 1'b1;
            end
          end else begin
            frame_out <= 1'b1;
            cnt       <= '0;
            if (buf_full) begin
              sr         <= shifted(buf_q);
              serial_out <= first_bit(buf_q);
              buf_q      <= '0;
              buf_full   <= 1'b0;
            end else if (accept) begin
              sr         <= shifted(data_in);
              serial_out <= first_bit(data_in);
            end else begin
              sr         <= '0;
              serial_out <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serializador.sv
// Directed bench: serializer feeding the 4-bit registrador, plus an LSB-first instance.
module tb_serializador;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] data_in, data_l;
  logic       load_valid, lv_l;
  logic       load_ready, serial_out, frame_out, busy;
  logic       ready_l, serial_l, frame_l, busy_l;
  logic [3:0] q;
  int         vecs = 0;
  int         miscompares = 0;

  always #5 clock = ~clock;

  serializador #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .serial_out(serial_out), .frame_out(frame_out), .busy(busy)
  );

  serializador_registrador #(.W(4)) u_reg (
    .clock(clock), .reset(reset), .serial_in(serial_out), .q(q)
  );

  serializador #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clock(clock), .reset(reset), .data_in(data_l), .load_valid(lv_l),
    .load_ready(ready_l), .serial_out(serial_l), .frame_out(frame_l), .busy(busy_l)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] hx(input byte ch);
    if (int'(ch) >= int'("a")) return 4'(int'(ch) - int'("a") + 10);
    return 4'(int'(ch) - int'("0"));
  endfunction

  // One character per cycle, starting at the cycle after the first accept.
  // lv/dat are the inputs driven for the edge that ends that cycle; qs '-' = no check.
  task automatic run(input string tag, input string ser, input string frm, input string rdy,
                     input string bsy, input string lv, input string dat, input string qs);
    for (int i = 0; i < ser.len(); i++) begin
      chk($sformatf("%s_ser_c%0d", tag, i+1), 32'(serial_out), 32'(ser[i] == "1"));
      chk($sformatf("%s_frm_c%0d", tag, i+1), 32'(frame_out),  32'(frm[i] == "1"));
      chk($sformatf("%s_rdy_c%0d", tag, i+1), 32'(load_ready), 32'(rdy[i] == "1"));
      chk($sformatf("%s_bsy_c%0d", tag, i+1), 32'(busy),       32'(bsy[i] == "1"));
      if (qs[i] != "-") chk($sformatf("%s_q_c%0d", tag, i+1), 32'(q), 32'(hx(qs[i])));
      load_valid = (lv[i] == "1");
      data_in    = hx(dat[i]);
      step();
    end
  endtask

  task automatic accept_first(input logic [3:0] w);
    data_in    = w;
    load_valid = 1'b1;
    step();
  endtask

  initial begin
    string lsb_ser;
    reset = 1'b0; load_valid = 1'b0; data_in = '0; lv_l = 1'b0; data_l = '0;
    #12;
    chk("rst_ser",   32'(serial_out), 32'd0);
    chk("rst_frm",   32'(frame_out),  32'd0);
    chk("rst_busy",  32'(busy),       32'd0);
    chk("rst_ready", 32'(load_ready), 32'd1);
    chk("rst_q",     32'(q),          32'd0);
    reset = 1'b1;

    // Accepted on the very first edge after release.
    accept_first(4'b1011);
    run("single", "10110", "00001", "11111", "11110", "00000", "00000", "----d");

    accept_first(4'b1100);
    run("b2b", "1100011000", "0000100010", "1000111111", "1111111100",
        "1000000000", "6000000000", "----3---6-");

    accept_first(4'b1010);
    run("bypass", "101001010", "000010001", "111111111", "111111110",
        "000100000", "000500000", "----5---a");

    accept_first(4'b1001);
    run("bp", "10010011011100", "00001000100010", "10001000111111", "11111111111100",
        "11111000000000", "3e777000000000", "----9---c---e-");

    // Abort mid-word with a second word sitting in the buffer.
    accept_first(4'b1111);
    data_in = 4'b0101;
    step();
    load_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort_ser",   32'(serial_out), 32'd0);
    chk("abort_busy",  32'(busy),       32'd0);
    chk("abort_ready", 32'(load_ready), 32'd1);
    chk("abort_frm",   32'(frame_out),  32'd0);
    #1;
    reset = 1'b1;
    step();
    run("post_abort", "000000", "000000", "111111", "000000", "000000", "000000", "------");

    lsb_ser = "10000";
    data_l = 4'b0001;
    lv_l   = 1'b1;
    step();
    lv_l = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("lsb_ser_c%0d", i+1), 32'(serial_l), 32'(lsb_ser[i] == "1"));
      chk($sformatf("lsb_frm_c%0d", i+1), 32'(frame_l),  32'(i == 4));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
